// File: rtl/nn_pkg.sv
// nn_pkg: shared types, constants and arithmetic helpers for the steering
// network inference sequencer.
//   - state_e     : sequencer phase (IDLE -> HID -> OUT -> ARG -> IDLE)
//   - mac_mode_e  : MAC term selection (conditional add / multiply-shift)
//   - sat/relu    : ACC_W -> DATA_W saturation and rectifier
//   - argmax3     : signed argmax of three scores, ties to the lowest index
//   - out_base    : first ROM address of the output layer for a given N_HID
package nn_pkg;

    localparam int DEF_DATA_W = 24;
    localparam int DEF_FRAC   = 16;
    localparam int DEF_N_HID  = 4;
    localparam int ACC_W      = 2 * DEF_DATA_W;
    localparam int HID_TERMS  = 7;  // six sensor inputs plus bias
    localparam int HID_BASE   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HID  = 2'd1,
        ST_OUT  = 2'd2,
        ST_ARG  = 2'd3
    } state_e;

    typedef enum logic {
        MAC_ADD = 1'b0,
        MAC_MUL = 1'b1
    } mac_mode_e;

    // Output-layer weights follow the hidden block: OUT_BASE = 7*N_HID.
    function automatic int out_base(input int n_hid);
        return HID_BASE + HID_TERMS * n_hid;
    endfunction

    // Clamp a wide signed accumulator into the signed DATA_W range.
    function automatic logic [DEF_DATA_W-1:0] sat(input logic signed [ACC_W-1:0] a);
        logic [ACC_W-DEF_DATA_W:0] top_s;
        logic [DEF_DATA_W-1:0]     res_s;
        top_s = a[ACC_W-1:DEF_DATA_W-1];
        // In range iff every bit above the result's sign bit equals that sign bit.
        if ((&top_s) || (~|top_s)) begin
            res_s = a[DEF_DATA_W-1:0];
        end else if (a[ACC_W-1]) begin
            res_s = {1'b1, {(DEF_DATA_W-1){1'b0}}};
        end else begin
            res_s = {1'b0, {(DEF_DATA_W-1){1'b1}}};
        end
        return res_s;
    endfunction

    function automatic logic [DEF_DATA_W-1:0] relu(input logic [DEF_DATA_W-1:0] x);
        logic [DEF_DATA_W-1:0] res_s;
        if (x[DEF_DATA_W-1]) begin
            res_s = {DEF_DATA_W{1'b0}};
        end else begin
            res_s = x;
        end
        return res_s;
    endfunction

    // Strict '>' comparisons keep the earlier index on ties.
    function automatic logic [1:0] argmax3(input logic signed [DEF_DATA_W-1:0] s0,
                                           input logic signed [DEF_DATA_W-1:0] s1,
                                           input logic signed [DEF_DATA_W-1:0] s2);
        logic [1:0]                   idx_s;
        logic signed [DEF_DATA_W-1:0] best_s;
        idx_s  = 2'd0;
        best_s = s0;
        if (s1 > best_s) begin
            idx_s  = 2'd1;
            best_s = s1;
        end else begin
            idx_s  = idx_s;
        end
        if (s2 > best_s) begin
            idx_s = 2'd2;
        end else begin
            idx_s = idx_s;
        end
        return idx_s;
    endfunction

endpackage

// File: rtl/nn_mac.sv
// nn_mac: the single shared multiply-accumulate unit.
//   clk, rst     : clock, synchronous active-high reset
//   clr          : zero the accumulator (first cycle of each neuron)
//   en           : accumulate the selected term this cycle
//   mode         : MAC_ADD -> add w when term_en; MAC_MUL -> add (act*w)>>>FRAC
//   term_en      : sensor bit / bias select for MAC_ADD
//   act, w       : activation and ROM weight
//   sat_val      : saturated value of (acc + term), valid in the writeback cycle
//   relu_val     : sat_val with negatives forced to zero
module nn_mac
    import nn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC   = DEF_FRAC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              mode,
    input  logic              term_en,
    input  logic [DATA_W-1:0] act,
    input  logic [DATA_W-1:0] w,
    output logic [DATA_W-1:0] sat_val,
    output logic [DATA_W-1:0] relu_val
);

    localparam int AW = 2 * DATA_W;

    logic signed [AW-1:0] acc_r;
    logic signed [AW-1:0] acc_nx_s;
    logic signed [AW-1:0] term_s;
    logic signed [AW-1:0] w_ext_s;
    logic signed [AW-1:0] act_ext_s;
    logic signed [AW-1:0] prod_s;

    // Term selection and the accumulator's next value.
    always_comb begin
        w_ext_s   = {{(AW-DATA_W){w[DATA_W-1]}}, w};
        act_ext_s = {{(AW-DATA_W){act[DATA_W-1]}}, act};
        // Both operands fit in DATA_W, so the low AW bits hold the exact product.
        prod_s    = act_ext_s * w_ext_s;
        term_s    = {AW{1'b0}};
        case (mode)
            MAC_ADD: begin
                if (term_en) begin
                    term_s = w_ext_s;
                end else begin
                    term_s = {AW{1'b0}};
                end
            end
            MAC_MUL: term_s = prod_s >>> FRAC;
            default: term_s = {AW{1'b0}};
        endcase
        acc_nx_s = acc_r + term_s;
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {AW{1'b0}};
        end else if (clr) begin
            acc_r <= {AW{1'b0}};
        end else if (en) begin
            acc_r <= acc_nx_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign sat_val  = sat(acc_nx_s);
    assign relu_val = relu(sat_val);

endmodule

// File: rtl/nn_infer_sequencer.sv
// nn_infer_sequencer: time-multiplexed inference of the steering network.
// One MAC walks the hidden layer (8 cycles per neuron) and then the three
// output neurons (N_HID+2 cycles each), fetching weights from a synchronous
// ROM with one cycle of read latency, and finally reports the argmax.
//   clk, rst                : clock, synchronous active-high reset
//   in_valid / in_ready     : sensor handshake; in_ready is high only in IDLE
//   sensors                 : {f,e,d,c,b,a}, captured at the handshake
//   w_addr / w_data         : weight ROM port (data one cycle after address)
//   dir_valid               : one-cycle pulse while dir is first presented
//   dir, score0..2          : argmax index and saturated scores, held
module nn_infer_sequencer
    import nn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC   = DEF_FRAC,
    parameter int N_HID  = DEF_N_HID,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        sensors,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              dir_valid,
    output logic [1:0]        dir,
    output logic [DATA_W-1:0] score0,
    output logic [DATA_W-1:0] score1,
    output logic [DATA_W-1:0] score2
);

    localparam int CNT_W    = 5;
    localparam int HIDX_W   = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int HID_LAST = HID_TERMS;      // drain/writeback cycle index
    localparam int OUT_LAST = N_HID + 1;      // bias arrives in this cycle
    localparam int OUT_B    = out_base(N_HID);

    state_e              state_r, state_nx_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nx_s;     // cycle within the current neuron
    logic [CNT_W-1:0]    neu_r, neu_nx_s;     // neuron index within the layer
    logic [5:0]          sens_r;
    logic [DATA_W-1:0]   hid_r [0:(1<<HIDX_W)-1];
    logic [DATA_W-1:0]   score0_r, score1_r, score2_r;
    logic [1:0]          dir_r;
    logic                dir_valid_r;
    logic                in_ready_r;
    logic [ADDR_W-1:0]   w_addr_r, addr_nx_s;

    logic                mac_clr_s, mac_en_s, mac_mode_s, mac_term_en_s;
    logic [DATA_W-1:0]   mac_act_s, sat_s, relu_s;
    logic                wb_hid_s, wb_out_s;
    // Data arriving this cycle belongs to the term addressed one cycle earlier.
    logic [2:0]          sidx_s;
    logic [HIDX_W-1:0]   hidx_s;

    assign sidx_s = 3'(cnt_r - 5'd1);
    assign hidx_s = HIDX_W'(cnt_r - 5'd1);

    // Phase sequencing: next state, neuron and cycle counters.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        neu_nx_s   = neu_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nx_s = ST_HID;
                    cnt_nx_s   = 5'd0;
                    neu_nx_s   = 5'd0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_HID: begin
                if (cnt_r == 5'(HID_LAST)) begin
                    cnt_nx_s = 5'd0;
                    if (neu_r == 5'(N_HID - 1)) begin
                        state_nx_s = ST_OUT;
                        neu_nx_s   = 5'd0;
                    end else begin
                        neu_nx_s = neu_r + 5'd1;
                    end
                end else begin
                    cnt_nx_s = cnt_r + 5'd1;
                end
            end
            ST_OUT: begin
                if (cnt_r == 5'(OUT_LAST)) begin
                    cnt_nx_s = 5'd0;
                    if (neu_r == 5'd2) begin
                        state_nx_s = ST_ARG;
                    end else begin
                        neu_nx_s = neu_r + 5'd1;
                    end
                end else begin
                    cnt_nx_s = cnt_r + 5'd1;
                end
            end
            ST_ARG:  state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // ROM address for the cycle about to start (registered into w_addr).
    always_comb begin
        addr_nx_s = {ADDR_W{1'b0}};
        case (state_nx_s)
            ST_HID:  addr_nx_s = ADDR_W'(HID_BASE + HID_TERMS * int'(neu_nx_s) + int'(cnt_nx_s));
            ST_OUT:  addr_nx_s = ADDR_W'(OUT_B + (N_HID + 1) * int'(neu_nx_s) + int'(cnt_nx_s));
            default: addr_nx_s = {ADDR_W{1'b0}};
        endcase
    end

    // MAC control and writeback strobes for the current cycle.
    always_comb begin
        mac_clr_s     = 1'b0;
        mac_en_s      = 1'b0;
        mac_mode_s    = MAC_ADD;
        mac_term_en_s = 1'b0;
        mac_act_s     = {DATA_W{1'b0}};
        wb_hid_s      = 1'b0;
        wb_out_s      = 1'b0;
        case (state_r)
            ST_HID: begin
                mac_clr_s = (cnt_r == 5'd0);
                mac_en_s  = (cnt_r != 5'd0);
                if (cnt_r == 5'(HID_LAST)) begin
                    mac_term_en_s = 1'b1;   // bias is always added
                    wb_hid_s      = 1'b1;
                end else begin
                    mac_term_en_s = sens_r[sidx_s];
                    wb_hid_s      = 1'b0;
                end
            end
            ST_OUT: begin
                mac_clr_s = (cnt_r == 5'd0);
                mac_en_s  = (cnt_r != 5'd0);
                if (cnt_r == 5'(OUT_LAST)) begin
                    mac_mode_s    = MAC_ADD;
                    mac_term_en_s = 1'b1;
                    wb_out_s      = 1'b1;
                end else begin
                    mac_mode_s = MAC_MUL;
                    mac_act_s  = hid_r[hidx_s];
                    wb_out_s   = 1'b0;
                end
            end
            default: begin
                mac_clr_s = 1'b0;
                mac_en_s  = 1'b0;
            end
        endcase
    end

    nn_mac #(
        .DATA_W (DATA_W),
        .FRAC   (FRAC)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (mac_clr_s),
        .en       (mac_en_s),
        .mode     (mac_mode_s),
        .term_en  (mac_term_en_s),
        .act      (mac_act_s),
        .w        (w_data),
        .sat_val  (sat_s),
        .relu_val (relu_s)
    );

    // State, capture, hidden regfile and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 5'd0;
            neu_r       <= 5'd0;
            sens_r      <= 6'd0;
            in_ready_r  <= 1'b1;
            w_addr_r    <= {ADDR_W{1'b0}};
            score0_r    <= {DATA_W{1'b0}};
            score1_r    <= {DATA_W{1'b0}};
            score2_r    <= {DATA_W{1'b0}};
            dir_r       <= 2'd0;
            dir_valid_r <= 1'b0;
            for (int i = 0; i < (1 << HIDX_W); i++) begin
                hid_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            neu_r      <= neu_nx_s;
            in_ready_r <= (state_nx_s == ST_IDLE);
            w_addr_r   <= addr_nx_s;
            if ((state_r == ST_IDLE) && in_valid) begin
                sens_r <= sensors;
            end
            if (wb_hid_s) begin
                hid_r[neu_r[HIDX_W-1:0]] <= relu_s;
            end
            if (wb_out_s) begin
                case (neu_r)
                    5'd0:    score0_r <= sat_s;
                    5'd1:    score1_r <= sat_s;
                    5'd2:    score2_r <= sat_s;
                    default: score0_r <= score0_r;
                endcase
            end
            // The argmax is resolved while score2 is written so that dir and
            // dir_valid are both presented during the ARG cycle.
            dir_valid_r <= wb_out_s && (neu_r == 5'd2);
            if (wb_out_s && (neu_r == 5'd2)) begin
                dir_r <= argmax3(score0_r, score1_r, sat_s);
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign w_addr    = w_addr_r;
    assign dir_valid = dir_valid_r;
    assign dir       = dir_r;
    assign score0    = score0_r;
    assign score1    = score1_r;
    assign score2    = score2_r;

endmodule

// File: tb/tb_nn_infer_sequencer.sv
// Bench for nn_infer_sequencer: directed and randomized inferences against
// an integer reference model of the network, plus latency, throughput and
// mid-inference reset behaviour.
module tb_nn_infer_sequencer;

    localparam int DATA_W = 24;
    localparam int FRAC   = 16;
    localparam int N_HID  = 4;
    localparam int ADDR_W = 6;
    localparam int LAT    = 8 * N_HID + 3 * (N_HID + 2) + 1;
    localparam int OB     = 7 * N_HID;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        sensors;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              dir_valid;
    logic [1:0]        dir;
    logic [DATA_W-1:0] score0, score1, score2;

    logic [DATA_W-1:0] rom [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] exp_sc [3];
    logic [1:0]        exp_dir;
    int                ncomp = 0;
    int                nfail = 0;

    nn_infer_sequencer #(
        .DATA_W (DATA_W), .FRAC (FRAC), .N_HID (N_HID), .ADDR_W (ADDR_W)
    ) dut (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
        .sensors (sensors), .w_addr (w_addr), .w_data (w_data),
        .dir_valid (dir_valid), .dir (dir),
        .score0 (score0), .score1 (score1), .score2 (score2)
    );

    always #5 clk = ~clk;

    // Synchronous weight ROM.
    always @(posedge clk) w_data <= rom[w_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [DATA_W-1:0] w);
        return longint'($signed(w));
    endfunction

    function automatic longint clampv(input longint v);
        if (v > 64'sd8388607) return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
    endfunction

    // Reference: evaluate the network directly from the ROM contents.
    task automatic model(input logic [5:0] s);
        longint hid [N_HID];
        longint sc [3];
        longint acc;
        int     best;
        for (int h = 0; h < N_HID; h++) begin
            acc = sx(rom[h*7 + 6]);
            for (int k = 0; k < 6; k++) if (s[k]) acc += sx(rom[h*7 + k]);
            acc = clampv(acc);
            hid[h] = (acc < 0) ? 64'sd0 : acc;
        end
        for (int o = 0; o < 3; o++) begin
            acc = sx(rom[OB + o*(N_HID+1) + N_HID]);
            for (int j = 0; j < N_HID; j++)
                acc += (hid[j] * sx(rom[OB + o*(N_HID+1) + j])) >>> FRAC;
            sc[o] = clampv(acc);
        end
        best = 0;
        for (int o = 1; o < 3; o++) if (sc[o] > sc[best]) best = o;
        for (int o = 0; o < 3; o++) exp_sc[o] = 24'(sc[o]);
        exp_dir = 2'(best);
    endtask

    task automatic set_rom(input logic [23:0] hw, input logic [23:0] hb,
                           input int ow_n, input logic [23:0] ow,
                           input int ob_n, input logic [23:0] ob);
        for (int a = 0; a < (1 << ADDR_W); a++) rom[a] = 24'd0;
        for (int h = 0; h < N_HID; h++) begin
            for (int k = 0; k < 6; k++) rom[h*7 + k] = hw;
            rom[h*7 + 6] = hb;
        end
        for (int j = 0; j < N_HID; j++) rom[OB + ow_n*(N_HID+1) + j] = ow;
        rom[OB + ob_n*(N_HID+1) + N_HID] = ob;
    endtask

    task automatic fill_rand(input bit full);
        for (int a = 0; a < (1 << ADDR_W); a++)
            rom[a] = full ? 24'($urandom) : 24'(int'($urandom_range(0, 262143)) - 131072);
    endtask

    task automatic check_results(input string tag);
        check({tag, "_dir"}, 32'(dir), 32'(exp_dir));
        check({tag, "_s0"}, 32'(score0), 32'(exp_sc[0]));
        check({tag, "_s1"}, 32'(score1), 32'(exp_sc[1]));
        check({tag, "_s2"}, 32'(score2), 32'(exp_sc[2]));
    endtask

    // One inference: handshake, wait (bounded) for dir_valid, check everything.
    task automatic run_one(input logic [5:0] s, input string tag);
        int cyc;
        bit seen;
        @(negedge clk);
        for (int n = 0; n < 100 && !in_ready; n++) @(negedge clk);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        model(s);
        sensors  = s;
        in_valid = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            sensors  = 6'($urandom);
            cyc++;
            if (dir_valid) seen = 1'b1;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_lat"}, 32'(cyc), 32'(LAT));
        check_results(tag);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(dir_valid), 32'd0);
        check({tag, "_rdy2"}, 32'(in_ready), 32'd1);
    endtask

    logic [5:0] hs_sens [$];
    int         hs_cyc [$];
    int         last_dv, nres;
    bit         dv_seen;
    logic [5:0] ps;
    int         pc;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        sensors  = 6'd0;
        set_rom(24'd0, 24'd0, 0, 24'd0, 0, 24'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdy", 32'(in_ready), 32'd1);
        check("rst_dv", 32'(dir_valid), 32'd0);
        check("rst_dir", 32'(dir), 32'd0);
        check("rst_s0", 32'(score0), 32'd0);
        check("rst_s1", 32'(score1), 32'd0);
        check("rst_s2", 32'(score2), 32'd0);
        check("rst_addr", 32'(w_addr), 32'd0);

        // Unit weights into neuron 1.
        set_rom(24'h010000, 24'd0, 1, 24'h010000, 0, 24'd0);
        run_one(6'b111111, "t1");
        check("t1_lit", 32'(score1), 32'h180000);

        // All-zero ROM: three-way tie.
        set_rom(24'd0, 24'd0, 0, 24'd0, 0, 24'd0);
        run_one(6'b101010, "t2");

        // Negative hidden sums clipped by ReLU; only the neuron 2 bias survives.
        set_rom(24'hFF0000, 24'd0, 0, 24'd0, 2, 24'h008000);
        run_one(6'b111111, "t3");
        check("t3_lit", 32'(score2), 32'h008000);

        // Positive and negative saturation.
        set_rom(24'h7FFFFF, 24'h7FFFFF, 0, 24'h7FFFFF, 0, 24'd0);
        run_one(6'b111111, "t4a");
        check("t4a_lit", 32'(score0), 32'h7FFFFF);
        set_rom(24'h7FFFFF, 24'h7FFFFF, 0, 24'h800000, 0, 24'd0);
        run_one(6'b111111, "t4b");
        check("t4b_lit", 32'(score0), 32'h800000);

        // Reset 20 cycles into an inference.
        fill_rand(1'b0);
        @(negedge clk);
        sensors  = 6'($urandom);
        in_valid = 1'b1;
        dv_seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (dir_valid) dv_seen = 1'b1;
        end
        check("t5_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        if (dir_valid) dv_seen = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        if (dir_valid) dv_seen = 1'b1;
        check("t5_nodv", 32'(dv_seen), 32'd0);
        check("t5_rdy", 32'(in_ready), 32'd1);
        check("t5_dir", 32'(dir), 32'd0);
        check("t5_s0", 32'(score0), 32'd0);
        check("t5_s1", 32'(score1), 32'd0);
        check("t5_s2", 32'(score2), 32'd0);
        run_one(6'($urandom), "t5_after");

        // Random inferences.
        for (int r = 0; r < 3; r++) begin
            fill_rand(1'b0);
            run_one(6'($urandom), "rnd");
        end
        fill_rand(1'b1);
        run_one(6'($urandom), "rndfull");

        // Back-to-back: in_valid held high, sensors change every cycle.
        fill_rand(1'b0);
        last_dv = -1;
        nres    = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            if (cyc >= 200 && hs_sens.size() == 0) break;
            if (dir_valid) begin
                if (hs_sens.size() == 0) begin
                    check("t6_unexpected", 32'd1, 32'd0);
                end else begin
                    ps = hs_sens.pop_front();
                    pc = hs_cyc.pop_front();
                    model(ps);
                    check_results("t6");
                    check("t6_lat", 32'(cyc - pc), 32'(LAT));
                    if (last_dv >= 0) check("t6_gap", 32'(cyc - last_dv), 32'(LAT + 1));
                    last_dv = cyc;
                    nres++;
                end
            end
            in_valid = (cyc < 200);
            sensors  = sensors ^ 6'($urandom_range(1, 63));
            if (in_valid && in_ready) begin
                hs_sens.push_back(sensors);
                hs_cyc.push_back(cyc);
            end
        end
        check("t6_drained", 32'(hs_sens.size()), 32'd0);
        check("t6_count", 32'(nres >= 3), 32'd1);
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
